// File: rtl/universal_shift_register_if.sv
// universal_shift_register_if: control/data bundle between a datapath master and the shift register
//   master drives enable, mode, in_lsb, in_msb, load_data, start, count
//   slave  drives busy, done, out, sout_msb, sout_lsb (and parity when USR_PARITY_EN is defined)
interface universal_shift_register_if #(parameter int DEPTH = 8, parameter int WIDTH = 1);
  localparam int CNT_W = $clog2(DEPTH + 1);
  logic enable;
  logic [2:0] mode;
  logic [WIDTH-1:0] in_lsb, in_msb;
  logic [DEPTH*WIDTH-1:0] load_data;
  logic start;
  logic [CNT_W-1:0] count;
  logic busy, done;
  logic [DEPTH*WIDTH-1:0] out;
  logic [WIDTH-1:0] sout_msb, sout_lsb;
`ifdef USR_PARITY_EN
  logic parity;
`endif
  modport master(
    output enable, mode, in_lsb, in_msb, load_data, start, count,
    input busy, done, out, sout_msb, sout_lsb
`ifdef USR_PARITY_EN
    , parity
`endif
  );
  modport slave(
    input enable, mode, in_lsb, in_msb, load_data, start, count,
    output busy, done, out, sout_msb, sout_lsb
`ifdef USR_PARITY_EN
    , parity
`endif
  );
endinterface

// File: rtl/universal_shift_register.sv
// universal_shift_register: DEPTH x WIDTH shift/rotate/load register with an N-shift burst engine
//   clk      rising-edge clock
//   reset_n  synchronous active-low reset
//   bus      universal_shift_register_if.slave: enable, mode, in_lsb, in_msb, load_data,
//            start, count in; busy, done, out, sout_msb, sout_lsb out
//   USR_PARITY_EN (optional define) adds bus.parity = ^out
module universal_shift_register #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 1
) (
  input logic clk,
  input logic reset_n,
  universal_shift_register_if.slave bus
);
  localparam int N = DEPTH * WIDTH;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [2:0] SHL = 3'd1, SHR = 3'd2, ROL = 3'd3, ROR = 3'd4, LOAD = 3'd5;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nx;
  logic [N-1:0] data, data_nx, sh;
  logic [2:0] bmode, sm;
  logic [CNT_W-1:0] remaining;
  logic accept;
  always_comb begin
    // a burst uses its latched mode; otherwise the live mode selects the shift
    sm = state == RUN ? bmode : bus.mode;
    sh = sm == SHL ? {data[N-WIDTH-1:0], bus.in_lsb} :
         sm == SHR ? {bus.in_msb, data[N-1:WIDTH]} :
         sm == ROL ? {data[N-WIDTH-1:0], data[N-1 -: WIDTH]} :
                     {data[WIDTH-1:0], data[N-1:WIDTH]};
    accept = state == IDLE && bus.start && bus.count != '0 && bus.count <= CNT_W'(DEPTH)
             && bus.mode inside {[SHL:ROR]};
    state_nx = state;
    data_nx = data;
    case (state)
      IDLE:
        if (accept) state_nx = RUN;
        else if (bus.enable) data_nx = bus.mode inside {[SHL:ROR]} ? sh : bus.mode == LOAD ? bus.load_data : data;
      RUN: begin
        data_nx = sh;
        state_nx = remaining == CNT_W'(1) ? DONE : RUN;
      end
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
      data <= '0;
      remaining <= '0;
      bmode <= '0;
    end else begin
      state <= state_nx;
      data <= data_nx;
      if (accept) begin
        remaining <= bus.count;
        bmode <= bus.mode;
      end else if (state == RUN) remaining <= remaining - CNT_W'(1);
    end
  end
  assign bus.out = data;
  assign bus.busy = state == RUN;
  assign bus.done = state == DONE;
  assign bus.sout_msb = data[N-1 -: WIDTH];
  assign bus.sout_lsb = data[WIDTH-1:0];
`ifdef USR_PARITY_EN
  assign bus.parity = ^data;
`endif
endmodule
